// File: rtl/fir_sequencer.sv
// Control sequencer for the tap-serial FIR datapath: coefficient serialiser and MAC strobe generator.
// Optional FIR_OVERRUN_EN adds a sticky flag for samples withdrawn before acceptance.
module fir_sequencer #(
    parameter int TAPS      = 4,
    parameter int COEF_BITS = 8,
    parameter int MULT_LAT  = 0,
    localparam int W  = TAPS * COEF_BITS,
    localparam int SW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic         ph1,
    input  logic         reset,
    input  logic         sampleValid,
    output logic         sampleReady,
    input  logic         coefValid,
    output logic         coefReady,
    input  logic [W-1:0] coefWord,
    output logic         shiftIn,
    output logic         shiftEn,
    output logic         dataCap,
    output logic         clearAccum,
    output logic [SW-1:0] muxSel,
    output logic         accEn,
    output logic         yValid,
`ifdef FIR_OVERRUN_EN
    output logic         overrun,
    input  logic         clrOverrun,
`endif
    output logic         busy
);

    localparam int BW   = $clog2(W);
    localparam int KW   = $clog2(TAPS + MULT_LAT) + 1;
    localparam int KMAX = TAPS + MULT_LAT - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        MAC,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [KW-1:0] tap_cnt_q, tap_cnt_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [KW:0]   k_plus1;
    logic          idle;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tap_cnt_q <= '0;
            sreg_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tap_cnt_q <= tap_cnt_d;
            sreg_q    <= sreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tap_cnt_d = tap_cnt_q;
        sreg_d    = sreg_q;
        case (state_q)
            IDLE: begin
                // coefficient load wins a simultaneous request
                if (coefValid) begin
                    state_d   = LOAD;
                    sreg_d    = coefWord;
                    bit_cnt_d = '0;
                end else if (sampleValid) begin
                    state_d = CAPTURE;
                end
            end
            LOAD: begin
                sreg_d = {sreg_q[W-2:0], 1'b0};
                if (bit_cnt_q == BW'(W - 1)) begin
                    state_d = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                state_d   = MAC;
                tap_cnt_d = '0;
            end
            MAC: begin
                if (tap_cnt_q == KW'(KMAX)) begin
                    state_d = DONE;
                end else begin
                    tap_cnt_d = tap_cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign idle    = (state_q == IDLE) && !reset;
    assign k_plus1 = {1'b0, tap_cnt_q} + (KW+1)'(1);

    always_comb begin
        sampleReady = 1'b0;
        coefReady   = 1'b0;
        shiftIn     = 1'b0;
        shiftEn     = 1'b0;
        dataCap     = 1'b0;
        clearAccum  = 1'b0;
        muxSel      = '0;
        accEn       = 1'b0;
        yValid      = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                coefReady   = idle;
                sampleReady = idle && !coefValid;
            end
            LOAD: begin
                shiftEn = 1'b1;
                shiftIn = sreg_q[W-1];
            end
            CAPTURE: begin
                dataCap    = 1'b1;
                clearAccum = 1'b1;
            end
            MAC: begin
                if (tap_cnt_q >= KW'(TAPS - 1)) begin
                    muxSel = SW'(TAPS - 1);
                end else begin
                    muxSel = tap_cnt_q[SW-1:0];
                end
                // k <= KMAX bounds the top of the accumulate window
                accEn = k_plus1 > (KW+1)'(MULT_LAT);
            end
            DONE:    yValid = 1'b1;
            default: ;
        endcase
    end

`ifdef FIR_OVERRUN_EN
    logic pend_q, pend_d;
    logic overrun_q, overrun_d;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        pend_d    = sampleValid && !sampleReady;
        overrun_d = overrun_q;
        if (pend_q && !sampleValid) begin
            overrun_d = 1'b1;
        end else if (clrOverrun) begin
            overrun_d = 1'b0;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: default instance plus a MULT_LAT=2 instance on shared inputs.
// Define FIR_OVERRUN_EN to also exercise the overrun flag.
module tb_fir_sequencer;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        sampleValid;
    logic        coefValid;
    logic [31:0] coefWord;

    logic a_sr, a_cr, a_si, a_se, a_dc, a_ca, a_ae, a_yv, a_bz;
    logic b_sr, b_cr, b_si, b_se, b_dc, b_ca, b_ae, b_yv, b_bz;
    logic [1:0] a_ms, b_ms;
`ifdef FIR_OVERRUN_EN
    logic clrOverrun;
    logic a_ov, b_ov;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ph1 = ~ph1;

    fir_sequencer #(.TAPS(4), .COEF_BITS(8), .MULT_LAT(0)) dut_a (
        .ph1(ph1), .reset(reset),
        .sampleValid(sampleValid), .sampleReady(a_sr),
        .coefValid(coefValid), .coefReady(a_cr), .coefWord(coefWord),
        .shiftIn(a_si), .shiftEn(a_se), .dataCap(a_dc),
        .clearAccum(a_ca), .muxSel(a_ms), .accEn(a_ae), .yValid(a_yv),
`ifdef FIR_OVERRUN_EN
        .overrun(a_ov), .clrOverrun(clrOverrun),
`endif
        .busy(a_bz)
    );

    fir_sequencer #(.TAPS(4), .COEF_BITS(8), .MULT_LAT(2)) dut_b (
        .ph1(ph1), .reset(reset),
        .sampleValid(sampleValid), .sampleReady(b_sr),
        .coefValid(coefValid), .coefReady(b_cr), .coefWord(coefWord),
        .shiftIn(b_si), .shiftEn(b_se), .dataCap(b_dc),
        .clearAccum(b_ca), .muxSel(b_ms), .accEn(b_ae), .yValid(b_yv),
`ifdef FIR_OVERRUN_EN
        .overrun(b_ov), .clrOverrun(clrOverrun),
`endif
        .busy(b_bz)
    );

    // {sr, cr, se, si, dc, ca, mux[1:0], ae, yv, busy}
    logic [10:0] a_o, b_o;
    assign a_o = {a_sr, a_cr, a_se, a_si, a_dc, a_ca, a_ms, a_ae, a_yv, a_bz};
    assign b_o = {b_sr, b_cr, b_se, b_si, b_dc, b_ca, b_ms, b_ae, b_yv, b_bz};

    function automatic logic [10:0] o(
        input logic sr, cr, se, si, dc,
        input logic [1:0] mux,
        input logic ae, yv, bz
    );
        return {sr, cr, se, si, dc, dc, mux, ae, yv, bz};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        sv;
        logic [10:0] ea;
        logic [10:0] eb;
    } vec_t;

    vec_t        tbl[10];
    logic [10:0] S_IDLE, S_CAP;
    logic [31:0] word;

    initial begin
        S_IDLE = o(1, 1, 0, 0, 0, 2'd0, 0, 0, 0);
        S_CAP  = o(0, 0, 0, 0, 1, 2'd0, 0, 0, 1);
        tbl[0] = '{1'b1, S_IDLE, S_IDLE};
        tbl[1] = '{1'b0, S_CAP, S_CAP};
        tbl[2] = '{1'b0, o(0,0,0,0,0,2'd0,1,0,1), o(0,0,0,0,0,2'd0,0,0,1)};
        tbl[3] = '{1'b0, o(0,0,0,0,0,2'd1,1,0,1), o(0,0,0,0,0,2'd1,0,0,1)};
        tbl[4] = '{1'b0, o(0,0,0,0,0,2'd2,1,0,1), o(0,0,0,0,0,2'd2,1,0,1)};
        tbl[5] = '{1'b0, o(0,0,0,0,0,2'd3,1,0,1), o(0,0,0,0,0,2'd3,1,0,1)};
        tbl[6] = '{1'b0, o(0,0,0,0,0,2'd0,0,1,1), o(0,0,0,0,0,2'd3,1,0,1)};
        tbl[7] = '{1'b0, S_IDLE,                  o(0,0,0,0,0,2'd3,1,0,1)};
        tbl[8] = '{1'b0, S_IDLE,                  o(0,0,0,0,0,2'd0,0,1,1)};
        tbl[9] = '{1'b0, S_IDLE, S_IDLE};

        reset       = 1'b1;
        sampleValid = 1'b0;
        coefValid   = 1'b0;
        coefWord    = '0;
`ifdef FIR_OVERRUN_EN
        clrOverrun  = 1'b0;
`endif
        @(negedge ph1);
        #1;
        chk("reset_a", 32'(a_o), 32'd0);
        chk("reset_b", 32'(b_o), 32'd0);
        @(negedge ph1);
        reset = 1'b0;
        #1;
        chk("post_reset_a", 32'(a_o), 32'(S_IDLE));
        chk("post_reset_b", 32'(b_o), 32'(S_IDLE));
`ifdef FIR_OVERRUN_EN
        chk("overrun_reset", 32'(a_ov), 32'd0);
`endif
        @(negedge ph1);

        // sample pass on both latencies
        for (int i = 0; i < 10; i++) begin
            sampleValid = tbl[i].sv;
            #1;
            chk($sformatf("pass_a[%0d]", i), 32'(a_o), 32'(tbl[i].ea));
            chk($sformatf("pass_b[%0d]", i), 32'(b_o), 32'(tbl[i].eb));
            @(negedge ph1);
        end

        // reset at MAC k=2
        sampleValid = 1'b1;
        @(negedge ph1);
        sampleValid = 1'b0;
        repeat (3) @(negedge ph1);
        #1;
        chk("pre_reset_k2_a", 32'(a_o), 32'(tbl[4].ea));
        reset = 1'b1;
        #1;
        chk("midmac_reset_a", 32'(a_o), 32'd0);
        chk("midmac_reset_b", 32'(b_o), 32'd0);
        @(negedge ph1);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("after_reset_a[%0d]", i), 32'(a_o), 32'(S_IDLE));
            chk($sformatf("after_reset_b[%0d]", i), 32'(b_o), 32'(S_IDLE));
            @(negedge ph1);
        end

        // coefficient load racing a held sample
        word        = 32'hA5C3_0F81;
        coefWord    = word;
        coefValid   = 1'b1;
        sampleValid = 1'b1;
        #1;
        chk("race_a", 32'(a_o), 32'(o(0, 1, 0, 0, 0, 2'd0, 0, 0, 0)));
        @(negedge ph1);
        coefValid = 1'b0;
        coefWord  = '0;
        for (int i = 1; i <= 32; i++) begin
            #1;
            chk($sformatf("load_a[%0d]", i), 32'(a_o),
                32'(o(0, 0, 1, word[32-i], 0, 2'd0, 0, 0, 1)));
            chk($sformatf("load_b[%0d]", i), 32'(b_o),
                32'(o(0, 0, 1, word[32-i], 0, 2'd0, 0, 0, 1)));
            @(negedge ph1);
        end
        #1;
        chk("load_done_a", 32'(a_o), 32'(S_IDLE));
        @(negedge ph1);
        sampleValid = 1'b0;
        #1;
        chk("held_sample_cap_a", 32'(a_o), 32'(S_CAP));
        chk("held_sample_cap_b", 32'(b_o), 32'(S_CAP));
        repeat (9) @(negedge ph1);

        // sample withdrawn while busy
        sampleValid = 1'b1;
        @(negedge ph1);
        sampleValid = 1'b0;
        repeat (2) @(negedge ph1);
        sampleValid = 1'b1;
        #1;
        chk("busy_not_ready_a", 32'(a_sr), 32'd0);
        @(negedge ph1);
        sampleValid = 1'b0;
`ifdef FIR_OVERRUN_EN
        #1;
        chk("overrun_pending", 32'(a_ov), 32'd0);
`endif
        @(negedge ph1);
`ifdef FIR_OVERRUN_EN
        #1;
        chk("overrun_set", 32'(a_ov), 32'd1);
`endif
        repeat (6) @(negedge ph1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("pulse_ignored_a[%0d]", i), 32'(a_o), 32'(S_IDLE));
            chk($sformatf("pulse_ignored_b[%0d]", i), 32'(b_o), 32'(S_IDLE));
            @(negedge ph1);
        end
`ifdef FIR_OVERRUN_EN
        chk("overrun_sticky", 32'(a_ov), 32'd1);
        clrOverrun = 1'b1;
        @(negedge ph1);
        clrOverrun = 1'b0;
        #1;
        chk("overrun_cleared", 32'(a_ov), 32'd0);
        @(negedge ph1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
